exe_hazard_unit: RTL and testbench
==================================

EXE_HAZARD_UNIT -- requirements
Module: exe_hazard_unit

Interface
REQ-001 Parameter FP_SINGLE_LAT, default 2, total EXE cycles for single-precision FP op; legal range 2..15.
REQ-002 Parameter FP_DOUBLE_LAT, default 4, total EXE cycles for double-precision FP op; legal range 2..15.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 ID_EXE_MemRead, ID_EXE_RegWrite, ID_EXE_FPLoadStore, ID_EXE_floatop, ID_EXE_double  in  1 each  control fields of instruction currently in EXE.
REQ-006 ID_EXE_RtReg, ID_EXE_Ft  in  5 each  load destination (integer / FP) of instruction in EXE.
REQ-007 IF_ID_Rs, IF_ID_Rt, IF_ID_Fs, IF_ID_Ft  in  5 each  source registers of instruction in ID.
REQ-008 BranchTaken  in  1  branch/jump resolved taken in EXE this cycle.
REQ-009 PCWrite  out  1  PC update enable.
REQ-010 IF_ID_Write  out  1  IF/ID register update enable.
REQ-011 IF_ID_Flush  out  1  IF/ID register loads a NOP.
REQ-012 ID_EXE_Hold  out  1  ID/EXE register keeps its contents.
REQ-013 ID_EXE_Bubble  out  1  ID/EXE register loads all-zero control fields.
REQ-014 FPBusy  out  1  multi-cycle FP op occupying EXE.
REQ-015 StallCount  out  16  saturating count of stall cycles.

Function
REQ-016 FSM states IDLE and FP_BUSY, plus 4-bit down-counter cnt; outputs combinational from state, cnt, inputs.
REQ-017 Default (no event): PCWrite=1, IF_ID_Write=1, all other 1-bit outputs 0.
REQ-018 Priority in IDLE, highest first: BranchTaken, FP start, integer/FP load-use; lower events ignored that cycle.
REQ-019 IDLE + BranchTaken: IF_ID_Flush=1, ID_EXE_Bubble=1, PCWrite=1; state stays IDLE.
REQ-020 Integer load-use: ID_EXE_MemRead & ID_EXE_RegWrite & !ID_EXE_FPLoadStore & ID_EXE_RtReg!=0 & (RtReg==IF_ID_Rs | RtReg==IF_ID_Rt).
REQ-021 FP load-use: ID_EXE_MemRead & ID_EXE_FPLoadStore & (ID_EXE_Ft==IF_ID_Fs | ID_EXE_Ft==IF_ID_Ft); FP register 0 not excluded.
REQ-022 Load-use in IDLE: PCWrite=0, IF_ID_Write=0, ID_EXE_Bubble=1 for exactly one cycle; state stays IDLE.
REQ-023 FP start (IDLE, ID_EXE_floatop=1): PCWrite=0, IF_ID_Write=0, ID_EXE_Hold=1, FPBusy=1 this cycle; next state FP_BUSY, cnt <= LAT-2, LAT = FP_DOUBLE_LAT if ID_EXE_double else FP_SINGLE_LAT.
REQ-024 FP_BUSY, cnt!=0: same outputs as REQ-023; cnt decrements.
REQ-025 FP_BUSY, cnt==0: release cycle; FPBusy=1, PCWrite=1, IF_ID_Write=1, ID_EXE_Hold=0; next state IDLE.
REQ-026 Net: FP op occupies EXE exactly LAT cycles with LAT-1 stall cycles; no retrigger on same op in release cycle.
REQ-027 In FP_BUSY, BranchTaken and load-use inputs ignored.
REQ-028 ID_EXE_Hold and ID_EXE_Bubble never both 1; IF_ID_Flush and IF_ID_Write=0 never together.
REQ-029 StallCount increments on every posedge where PCWrite=0; saturates at 16'hFFFF.

Reset
REQ-030 rst_n=0 immediately (asynchronously): state=IDLE, cnt=0, StallCount=0.
REQ-031 While rst_n=0: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EXE_Hold=0, ID_EXE_Bubble=0, FPBusy=0, regardless of inputs.
REQ-032 Reset during FP_BUSY aborts the op; first cycle after release evaluates inputs as IDLE.

Verification
REQ-033 Load-use: MemRead=1, RegWrite=1, RtReg=5, IF_ID_Rs=5 -> one cycle PCWrite=0, IF_ID_Write=0, Bubble=1; StallCount=1; RtReg=0 -> no stall.
REQ-034 Double FP: floatop=1, double=1 held in EXE -> 3 stall cycles with Hold=1, FPBusy=1 for 4 cycles, 4th cycle PCWrite=1; StallCount=3.
REQ-035 Single FP: floatop=1, double=0 -> 1 stall cycle, release next cycle, back to IDLE.
REQ-036 BranchTaken=1 with load-use condition -> Flush=1, Bubble=1, PCWrite=1, no stall, StallCount unchanged.
REQ-037 rst_n low at FP_BUSY cnt=1 -> outputs to defaults without clock edge; after release with floatop=0, no stall.
REQ-038 Force 65540 stall cycles -> StallCount holds 16'hFFFF.

Source files
------------

// File: rtl/exe_hazard_unit.sv
// EXE-stage hazard controller: branch flush, integer/FP load-use stalls and
// multi-cycle FP occupancy of EXE, plus a saturating stall-cycle counter.
module exe_hazard_unit #(
    parameter int FP_SINGLE_LAT = 2,
    parameter int FP_DOUBLE_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ID_EXE_MemRead,
    input  logic        ID_EXE_RegWrite,
    input  logic        ID_EXE_FPLoadStore,
    input  logic        ID_EXE_floatop,
    input  logic        ID_EXE_double,
    input  logic [4:0]  ID_EXE_RtReg,
    input  logic [4:0]  ID_EXE_Ft,
    input  logic [4:0]  IF_ID_Rs,
    input  logic [4:0]  IF_ID_Rt,
    input  logic [4:0]  IF_ID_Fs,
    input  logic [4:0]  IF_ID_Ft,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EXE_Hold,
    output logic        ID_EXE_Bubble,
    output logic        FPBusy,
    output logic [15:0] StallCount
);

    typedef enum logic {S_IDLE, S_FP_BUSY} state_t;

    // Counter preload is LAT-2: the start cycle and the release cycle are
    // both outside the counted window.
    localparam logic [3:0] LAT_SINGLE_M2 = 4'(FP_SINGLE_LAT - 2);
    localparam logic [3:0] LAT_DOUBLE_M2 = 4'(FP_DOUBLE_LAT - 2);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [15:0] r_stall_cnt;

    logic w_int_lu;
    logic w_fp_lu;
    logic w_load_use;
    logic w_pc_wr;
    logic w_ifid_wr;
    logic w_ifid_flush;
    logic w_hold;
    logic w_bubble;
    logic w_fp_busy;

    assign w_int_lu = ID_EXE_MemRead && ID_EXE_RegWrite && !ID_EXE_FPLoadStore &&
                      (ID_EXE_RtReg != 5'd0) &&
                      ((ID_EXE_RtReg == IF_ID_Rs) || (ID_EXE_RtReg == IF_ID_Rt));
    // FP register 0 is a real register, so no zero exclusion here.
    assign w_fp_lu  = ID_EXE_MemRead && ID_EXE_FPLoadStore &&
                      ((ID_EXE_Ft == IF_ID_Fs) || (ID_EXE_Ft == IF_ID_Ft));
    assign w_load_use = w_int_lu || w_fp_lu;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_pc_wr      = 1'b1;
        w_ifid_wr    = 1'b1;
        w_ifid_flush = 1'b0;
        w_hold       = 1'b0;
        w_bubble     = 1'b0;
        w_fp_busy    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (BranchTaken) begin
                    w_ifid_flush = 1'b1;
                    w_bubble     = 1'b1;
                end else if (ID_EXE_floatop) begin
                    w_pc_wr     = 1'b0;
                    w_ifid_wr   = 1'b0;
                    w_hold      = 1'b1;
                    w_fp_busy   = 1'b1;
                    w_state_nxt = S_FP_BUSY;
                    w_cnt_nxt   = ID_EXE_double ? LAT_DOUBLE_M2 : LAT_SINGLE_M2;
                end else if (w_load_use) begin
                    w_pc_wr   = 1'b0;
                    w_ifid_wr = 1'b0;
                    w_bubble  = 1'b1;
                end
            end
            S_FP_BUSY: begin
                w_fp_busy = 1'b1;
                if (r_cnt != 4'd0) begin
                    w_pc_wr   = 1'b0;
                    w_ifid_wr = 1'b0;
                    w_hold    = 1'b1;
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    // Release cycle: the op leaves EXE, so its floatop must not retrigger.
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Reset forces the default handshake immediately, independent of the clock.
    assign PCWrite       = w_pc_wr   || !rst_n;
    assign IF_ID_Write   = w_ifid_wr || !rst_n;
    assign IF_ID_Flush   = w_ifid_flush && rst_n;
    assign ID_EXE_Hold   = w_hold       && rst_n;
    assign ID_EXE_Bubble = w_bubble     && rst_n;
    assign FPBusy        = w_fp_busy    && rst_n;
    assign StallCount    = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (!w_pc_wr && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_exe_hazard_unit.sv
// Scoreboard bench for exe_hazard_unit: expected control vectors are queued as
// stimulus is applied and popped on the falling edge for comparison.
module tb_exe_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ID_EXE_MemRead, ID_EXE_RegWrite, ID_EXE_FPLoadStore;
    logic        ID_EXE_floatop, ID_EXE_double;
    logic [4:0]  ID_EXE_RtReg, ID_EXE_Ft;
    logic [4:0]  IF_ID_Rs, IF_ID_Rt, IF_ID_Fs, IF_ID_Ft;
    logic        BranchTaken;
    logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EXE_Hold, ID_EXE_Bubble, FPBusy;
    logic [15:0] StallCount;

    // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EXE_Hold, ID_EXE_Bubble, FPBusy}
    localparam logic [5:0] C_DEF  = 6'b110000;
    localparam logic [5:0] C_BR   = 6'b111010;
    localparam logic [5:0] C_LU   = 6'b000010;
    localparam logic [5:0] C_FPST = 6'b000101;
    localparam logic [5:0] C_REL  = 6'b110001;

    typedef struct {
        logic [5:0]  ctl;
        logic [15:0] sc;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] sc_m  = 16'd0;

    exe_hazard_unit #(.FP_SINGLE_LAT(2), .FP_DOUBLE_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_EXE_MemRead(ID_EXE_MemRead), .ID_EXE_RegWrite(ID_EXE_RegWrite),
        .ID_EXE_FPLoadStore(ID_EXE_FPLoadStore), .ID_EXE_floatop(ID_EXE_floatop),
        .ID_EXE_double(ID_EXE_double), .ID_EXE_RtReg(ID_EXE_RtReg), .ID_EXE_Ft(ID_EXE_Ft),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_Fs(IF_ID_Fs), .IF_ID_Ft(IF_ID_Ft),
        .BranchTaken(BranchTaken), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .IF_ID_Flush(IF_ID_Flush), .ID_EXE_Hold(ID_EXE_Hold), .ID_EXE_Bubble(ID_EXE_Bubble),
        .FPBusy(FPBusy), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EXE_Hold, ID_EXE_Bubble, FPBusy};
    endfunction

    task automatic clr_in();
        ID_EXE_MemRead = 0; ID_EXE_RegWrite = 0; ID_EXE_FPLoadStore = 0;
        ID_EXE_floatop = 0; ID_EXE_double = 0; BranchTaken = 0;
        ID_EXE_RtReg = 0; ID_EXE_Ft = 5'd31; IF_ID_Rs = 5'd1; IF_ID_Rt = 5'd2;
        IF_ID_Fs = 5'd3; IF_ID_Ft = 5'd4;
    endtask

    task automatic set_int_lu(input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] irt);
        ID_EXE_MemRead = 1; ID_EXE_RegWrite = 1; ID_EXE_RtReg = rt; IF_ID_Rs = rs; IF_ID_Rt = irt;
    endtask

    task automatic test_reset();
        exp_t ob;
        rst_n = 1'b0;
        set_int_lu(5'd5, 5'd5, 5'd0);
        ID_EXE_floatop = 1; BranchTaken = 1;
        exp_q.push_back('{C_DEF, 16'd0, "reset_outputs"});
        #3;
        ob = exp_q.pop_front(); n_vec++;
        if (outs() !== ob.ctl || StallCount !== ob.sc) begin
            n_err++;
            $display("FAIL %s: got ctl=%b sc=%0d, want ctl=%b sc=%0d", ob.name, outs(), StallCount, ob.ctl, ob.sc);
        end
        clr_in();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        sc_m = 16'd0;
    endtask

    task automatic test_load_use();
        exp_t ob;
        logic [5:0] e [7] = '{C_LU, C_DEF, C_LU, C_DEF, C_DEF, C_LU, C_DEF};
        for (int i = 0; i < 7; i++) begin
            clr_in();
            case (i)
                0: set_int_lu(5'd5, 5'd5, 5'd0);
                2: set_int_lu(5'd9, 5'd1, 5'd9);
                3: set_int_lu(5'd0, 5'd0, 5'd0);
                4: begin set_int_lu(5'd5, 5'd5, 5'd0); ID_EXE_FPLoadStore = 1; ID_EXE_Ft = 5'd7; end
                5: begin ID_EXE_MemRead = 1; ID_EXE_FPLoadStore = 1; ID_EXE_Ft = 5'd0; IF_ID_Fs = 5'd0; end
                6: begin set_int_lu(5'd5, 5'd5, 5'd0); ID_EXE_RegWrite = 0; end
                default: ;
            endcase
            exp_q.push_back('{e[i], sc_m, $sformatf("load_use_%0d", i)});
            @(negedge clk);
            ob = exp_q.pop_front(); n_vec++;
            if (outs() !== ob.ctl || StallCount !== ob.sc) begin
                n_err++;
                $display("FAIL %s: got ctl=%b sc=%0d, want ctl=%b sc=%0d", ob.name, outs(), StallCount, ob.ctl, ob.sc);
            end
            @(posedge clk); #1;
            if (!ob.ctl[5] && sc_m != 16'hFFFF) sc_m++;
        end
    endtask

    // Double op held in EXE; mid-occupancy branch and load-use must be ignored.
    task automatic test_fp_double();
        exp_t ob;
        logic [5:0] e [6] = '{C_FPST, C_FPST, C_FPST, C_REL, C_DEF, C_DEF};
        for (int i = 0; i < 6; i++) begin
            clr_in();
            if (i < 4) begin ID_EXE_floatop = 1; ID_EXE_double = 1; end
            if (i == 1 || i == 3) begin BranchTaken = 1; set_int_lu(5'd5, 5'd5, 5'd0); end
            exp_q.push_back('{e[i], sc_m, $sformatf("fp_double_%0d", i)});
            @(negedge clk);
            ob = exp_q.pop_front(); n_vec++;
            if (outs() !== ob.ctl || StallCount !== ob.sc) begin
                n_err++;
                $display("FAIL %s: got ctl=%b sc=%0d, want ctl=%b sc=%0d", ob.name, outs(), StallCount, ob.ctl, ob.sc);
            end
            @(posedge clk); #1;
            if (!ob.ctl[5] && sc_m != 16'hFFFF) sc_m++;
        end
    endtask

    task automatic test_fp_single();
        exp_t ob;
        logic [5:0] e [3] = '{C_FPST, C_REL, C_DEF};
        for (int i = 0; i < 3; i++) begin
            clr_in();
            if (i < 2) ID_EXE_floatop = 1;
            exp_q.push_back('{e[i], sc_m, $sformatf("fp_single_%0d", i)});
            @(negedge clk);
            ob = exp_q.pop_front(); n_vec++;
            if (outs() !== ob.ctl || StallCount !== ob.sc) begin
                n_err++;
                $display("FAIL %s: got ctl=%b sc=%0d, want ctl=%b sc=%0d", ob.name, outs(), StallCount, ob.ctl, ob.sc);
            end
            @(posedge clk); #1;
            if (!ob.ctl[5] && sc_m != 16'hFFFF) sc_m++;
        end
    endtask

    task automatic test_branch();
        exp_t ob;
        logic [5:0] e [4] = '{C_BR, C_BR, C_DEF, C_LU};
        for (int i = 0; i < 4; i++) begin
            clr_in();
            case (i)
                0: begin BranchTaken = 1; set_int_lu(5'd5, 5'd5, 5'd0); end
                1: begin BranchTaken = 1; ID_EXE_floatop = 1; ID_EXE_double = 1; end
                3: set_int_lu(5'd12, 5'd3, 5'd12);
                default: ;
            endcase
            exp_q.push_back('{e[i], sc_m, $sformatf("branch_%0d", i)});
            @(negedge clk);
            ob = exp_q.pop_front(); n_vec++;
            if (outs() !== ob.ctl || StallCount !== ob.sc) begin
                n_err++;
                $display("FAIL %s: got ctl=%b sc=%0d, want ctl=%b sc=%0d", ob.name, outs(), StallCount, ob.ctl, ob.sc);
            end
            @(posedge clk); #1;
            if (!ob.ctl[5] && sc_m != 16'hFFFF) sc_m++;
        end
    endtask

    // Reset asserted mid-cycle while the counter sits at 1.
    task automatic test_reset_busy();
        exp_t ob;
        clr_in();
        ID_EXE_floatop = 1; ID_EXE_double = 1;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.push_back('{C_DEF, 16'd0, "reset_in_busy"});
        #1;
        ob = exp_q.pop_front(); n_vec++;
        if (outs() !== ob.ctl || StallCount !== ob.sc) begin
            n_err++;
            $display("FAIL %s: got ctl=%b sc=%0d, want ctl=%b sc=%0d", ob.name, outs(), StallCount, ob.ctl, ob.sc);
        end
        ID_EXE_floatop = 0;
        @(negedge clk); rst_n = 1'b1;
        sc_m = 16'd0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{C_DEF, sc_m, $sformatf("after_reset_%0d", i)});
            @(negedge clk);
            ob = exp_q.pop_front(); n_vec++;
            if (outs() !== ob.ctl || StallCount !== ob.sc) begin
                n_err++;
                $display("FAIL %s: got ctl=%b sc=%0d, want ctl=%b sc=%0d", ob.name, outs(), StallCount, ob.ctl, ob.sc);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        exp_t ob;
        clr_in();
        set_int_lu(5'd7, 5'd7, 5'd0);
        repeat (65540) @(posedge clk);
        #1;
        sc_m = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{C_LU, sc_m, $sformatf("saturate_%0d", i)});
            @(negedge clk);
            ob = exp_q.pop_front(); n_vec++;
            if (outs() !== ob.ctl || StallCount !== ob.sc) begin
                n_err++;
                $display("FAIL %s: got ctl=%b sc=%0d, want ctl=%b sc=%0d", ob.name, outs(), StallCount, ob.ctl, ob.sc);
            end
            @(posedge clk); #1;
        end
        clr_in();
    endtask

    initial begin
        clr_in();
        rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_fp_double();
        test_fp_single();
        test_branch();
        test_reset_busy();
        test_saturation();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
